pipe_hazard_arbiter: RTL and testbench

Parametrised pipeline stall/flush arbiter that replaces the fixed six-stage controller. It resolves hazard requests from IF, ID, EX, MEM and WB into per-stage stall and flush vectors using parameterised class masks. It adds behaviour the fixed controller lacks:
- a post-reset flush window;
- a req/ack handshake for redirects, so each jump or trap flushes exactly once;
- a stall watchdog;
- saturating performance counters.

---
 rtl/pipe_hazard_arbiter.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_arbiter.sv
// Pipeline stall/flush arbiter: resolves per-stage hazard requests into stall/flush
// vectors by fixed class priority, with init flush, redirect handshakes, watchdog and counters.
module pipe_hazard_arbiter #(
    parameter int                STAGES     = 6,
    parameter int                INIT_FLUSH = 2,
    parameter int                TIMEOUT    = 1024,
    parameter int                CNT_W      = 32,
    parameter logic [STAGES-1:0] MEM_STALL  = 6'b001101,
    parameter logic [STAGES-1:0] MEM_FLUSH  = 6'b010000,
    parameter logic [STAGES-1:0] IF_STALL   = 6'b001101,
    parameter logic [STAGES-1:0] IF_FLUSH   = 6'b000000,
    parameter logic [STAGES-1:0] TRF_STALL  = 6'b000010,
    parameter logic [STAGES-1:0] TRF_FLUSH  = 6'b001110,
    parameter logic [STAGES-1:0] TRS_STALL  = 6'b111111,
    parameter logic [STAGES-1:0] TRS_FLUSH  = 6'b001110,
    parameter logic [STAGES-1:0] JMP_STALL  = 6'b000010,
    parameter logic [STAGES-1:0] JMP_FLUSH  = 6'b000110,
    parameter logic [STAGES-1:0] MD_STALL   = 6'b000111,
    parameter logic [STAGES-1:0] MD_FLUSH   = 6'b001000,
    parameter logic [STAGES-1:0] LU_STALL   = 6'b000011,
    parameter logic [STAGES-1:0] LU_FLUSH   = 6'b000100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_stall_i,
    input  logic              if_stall_i,
    input  logic              trap_req_i,
    input  logic              trap_stall_i,
    input  logic              jump_req_i,
    input  logic              muldiv_busy_i,
    input  logic              load_use_i,
    input  logic              clr_cnt_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              jump_ack_o,
    output logic              trap_ack_o,
    output logic              hang_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_count_o
);

    localparam int IW = (INIT_FLUSH < 1) ? 1 : $clog2(INIT_FLUSH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] INIT_VAL = IW'(INIT_FLUSH);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);

    typedef enum logic [3:0] {
        CLS_IDLE,
        CLS_INIT,
        CLS_MEM,
        CLS_IF,
        CLS_TRF,
        CLS_TRS,
        CLS_JMP,
        CLS_MD,
        CLS_LU
    } cls_t;

    cls_t              cls;
    logic [STAGES-1:0] stall_sel;
    logic [STAGES-1:0] flush_sel;
    logic [IW-1:0]     init_cnt;
    logic              init_active;
    logic              trap_used;
    logic              jump_used;
    logic [WW-1:0]     wd_cnt;
    logic              hang;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign init_active = (init_cnt != '0);

    // Class selection: a consumed redirect is invisible until its req drops.
    always_comb begin
        cls = CLS_IDLE;
        if (init_active)                    cls = CLS_INIT;
        else if (mem_stall_i)               cls = CLS_MEM;
        else if (if_stall_i)                cls = CLS_IF;
        else if (trap_req_i && !trap_used)  cls = CLS_TRF;
        else if (trap_stall_i)              cls = CLS_TRS;
        else if (jump_req_i && !jump_used)  cls = CLS_JMP;
        else if (muldiv_busy_i)             cls = CLS_MD;
        else if (load_use_i)                cls = CLS_LU;
    end

    always_comb begin
        stall_sel = '0;
        flush_sel = '0;
        case (cls)
            CLS_INIT: begin stall_sel = '0;        flush_sel = '1;        end
            CLS_MEM:  begin stall_sel = MEM_STALL; flush_sel = MEM_FLUSH; end
            CLS_IF:   begin stall_sel = IF_STALL;  flush_sel = IF_FLUSH;  end
            CLS_TRF:  begin stall_sel = TRF_STALL; flush_sel = TRF_FLUSH; end
            CLS_TRS:  begin stall_sel = TRS_STALL; flush_sel = TRS_FLUSH; end
            CLS_JMP:  begin stall_sel = JMP_STALL; flush_sel = JMP_FLUSH; end
            CLS_MD:   begin stall_sel = MD_STALL;  flush_sel = MD_FLUSH;  end
            CLS_LU:   begin stall_sel = LU_STALL;  flush_sel = LU_FLUSH;  end
            default:  begin stall_sel = '0;        flush_sel = '0;        end
        endcase
    end

    // Reset must force the outputs without waiting for a clock edge.
    assign stall_o    = rst_n ? stall_sel : '0;
    assign flush_o    = rst_n ? flush_sel : '1;
    assign trap_ack_o = rst_n && (cls == CLS_TRF);
    assign jump_ack_o = rst_n && (cls == CLS_JMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= INIT_VAL;
        end else if (init_active) begin
            init_cnt <= init_cnt - IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_used <= 1'b0;
            jump_used <= 1'b0;
        end else begin
            if (!trap_req_i)     trap_used <= 1'b0;
            else if (trap_ack_o) trap_used <= 1'b1;
            if (!jump_req_i)     jump_used <= 1'b0;
            else if (jump_ack_o) jump_used <= 1'b1;
        end
    end

    // Watchdog counts consecutive PC-hold cycles; the flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            hang   <= 1'b0;
        end else if (stall_o[0]) begin
            if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WW'(1);
            if (wd_cnt >= WD_LAST) hang <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (clr_cnt_i) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!init_active && (stall_o != '0))
                stall_cycles <= sat_inc(stall_cycles);
            if (trap_ack_o || jump_ack_o)
                flush_count <= sat_inc(flush_count);
        end
    end

    assign hang_o         = hang;
    assign stall_cycles_o = stall_cycles;
    assign flush_count_o  = flush_count;

    a_one_ack: assert property (@(posedge clk) disable iff (!rst_n) !(trap_ack_o && jump_ack_o));

endmodule

// File: tb/tb_pipe_hazard_arbiter.sv
// Directed bench for pipe_hazard_arbiter with INIT_FLUSH=2, TIMEOUT=4, CNT_W=4.
module tb_pipe_hazard_arbiter;

    localparam int STAGES = 6;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_stall_i, if_stall_i, trap_req_i, trap_stall_i;
    logic              jump_req_i, muldiv_busy_i, load_use_i, clr_cnt_i;
    logic [STAGES-1:0] stall_o, flush_o;
    logic              jump_ack_o, trap_ack_o, hang_o;
    logic [CNT_W-1:0]  stall_cycles_o, flush_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_arbiter #(
        .STAGES(STAGES), .INIT_FLUSH(2), .TIMEOUT(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_stall_i(mem_stall_i), .if_stall_i(if_stall_i),
        .trap_req_i(trap_req_i), .trap_stall_i(trap_stall_i),
        .jump_req_i(jump_req_i), .muldiv_busy_i(muldiv_busy_i),
        .load_use_i(load_use_i), .clr_cnt_i(clr_cnt_i),
        .stall_o(stall_o), .flush_o(flush_o),
        .jump_ack_o(jump_ack_o), .trap_ack_o(trap_ack_o), .hang_o(hang_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 unit after the rising edge; checks happen 4 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {clr, lu, md, jump, trs, trap, if, mem}
    task automatic drive(input logic [7:0] v);
        {clr_cnt_i, load_use_i, muldiv_busy_i, jump_req_i,
         trap_stall_i, trap_req_i, if_stall_i, mem_stall_i} = v;
        #3;
    endtask

    task automatic check_sf(input string tag, input logic [5:0] s, input logic [5:0] f,
                            input logic ja, input logic ta);
        check_eq({tag, "_stall"}, 32'(stall_o), 32'(s));
        check_eq({tag, "_flush"}, 32'(flush_o), 32'(f));
        check_eq({tag, "_jack"},  32'(jump_ack_o), 32'(ja));
        check_eq({tag, "_tack"},  32'(trap_ack_o), 32'(ta));
    endtask

    localparam logic [7:0] NONE = 8'h00, MEM = 8'h01, TRAP = 8'h04,
                           JMP = 8'h10, MD = 8'h20, LU = 8'h40, CLR = 8'h80;

    initial begin
        rst_n = 1'b0;
        drive(NONE);
        tick(); tick();
        check_sf("rst", 6'b000000, 6'b111111, 1'b0, 1'b0);
        check_eq("rst_hang", 32'(hang_o), 32'd0);
        check_eq("rst_scyc", 32'(stall_cycles_o), 32'd0);
        check_eq("rst_fcnt", 32'(flush_count_o), 32'd0);

        // Init window: two full-flush cycles, requests ignored.
        tick(); rst_n = 1'b1;
        drive(NONE);
        check_sf("init1", 6'b000000, 6'b111111, 1'b0, 1'b0);
        tick(); drive(JMP);
        check_sf("init2_jmp", 6'b000000, 6'b111111, 1'b0, 1'b0);
        tick(); drive(NONE);
        check_sf("idle", 6'b000000, 6'b000000, 1'b0, 1'b0);
        check_eq("idle_scyc", 32'(stall_cycles_o), 32'd0);

        // Load-use for one cycle.
        tick(); drive(LU);
        check_sf("lu", 6'b000011, 6'b000100, 1'b0, 1'b0);
        tick(); drive(NONE);
        check_eq("lu_scyc", 32'(stall_cycles_o), 32'd1);
        check_eq("lu_fcnt", 32'(flush_count_o), 32'd0);

        // Jump deferred behind MEM, applied once, no re-ack while held.
        tick(); drive(JMP | MEM);
        check_sf("jm1", 6'b001101, 6'b010000, 1'b0, 1'b0);
        tick(); drive(JMP | MEM);
        check_sf("jm2", 6'b001101, 6'b010000, 1'b0, 1'b0);
        tick(); drive(JMP);
        check_sf("jm3", 6'b000010, 6'b000110, 1'b1, 1'b0);
        tick(); drive(JMP);
        check_sf("jm4", 6'b000000, 6'b000000, 1'b0, 1'b0);
        tick(); drive(NONE);
        check_eq("jm_fcnt", 32'(flush_count_o), 32'd1);
        check_eq("jm_scyc", 32'(stall_cycles_o), 32'd4);
        check_eq("jm_hang", 32'(hang_o), 32'd0);

        // Trap beats jump; held trap does not re-ack.
        tick(); drive(TRAP | JMP);
        check_sf("tj", 6'b000010, 6'b001110, 1'b0, 1'b1);
        tick(); drive(TRAP);
        check_sf("t_held", 6'b000000, 6'b000000, 1'b0, 1'b0);
        tick(); drive(NONE);
        check_eq("tj_fcnt", 32'(flush_count_o), 32'd2);
        check_eq("tj_scyc", 32'(stall_cycles_o), 32'd5);

        // Watchdog: four muldiv stall cycles, hang rises on the fifth.
        for (int i = 0; i < 4; i++) begin
            tick(); drive(MD);
            check_sf("md", 6'b000111, 6'b001000, 1'b0, 1'b0);
        end
        check_eq("wd_pre", 32'(hang_o), 32'd0);
        tick(); drive(NONE);
        check_eq("wd_hang", 32'(hang_o), 32'd1);
        check_eq("wd_scyc", 32'(stall_cycles_o), 32'd9);

        // Saturation of the 4-bit stall counter, then clear with stall active.
        for (int i = 0; i < 10; i++) begin
            tick(); drive(MD);
        end
        tick(); drive(CLR | MD);
        check_eq("sat_scyc", 32'(stall_cycles_o), 32'hF);
        tick(); drive(NONE);
        check_eq("clr_scyc", 32'(stall_cycles_o), 32'd0);
        check_eq("clr_fcnt", 32'(flush_count_o), 32'd0);
        tick(); drive(NONE);
        check_eq("hang_sticky", 32'(hang_o), 32'd1);

        // Mid-cycle reset aborts a live ack.
        tick(); drive(JMP);
        check_sf("pre_rst", 6'b000010, 6'b000110, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_sf("async_rst", 6'b000000, 6'b111111, 1'b0, 1'b0);
        check_eq("async_hang", 32'(hang_o), 32'd0);
        check_eq("async_fcnt", 32'(flush_count_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
